// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-pointer search, owner keeps the grant while req
// stays high, with a hold timeout that pre-empts a long owner when others wait.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            preempt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int SW   = ID_W + 1;

  logic [0:0]      state;
  logic [ID_W-1:0] ptr;
  logic [HC_W-1:0] hold_cnt;

  logic [ID_W-1:0] winner;
  logic            found;
  logic [SW-1:0]   scan_idx;
  logic [ID_W-1:0] ptr_after_owner;
  logic            owner_req;
  logic            others_wait;
  logic            timeout;

  // Scan req starting at ptr, wrapping modulo N; the first set bit wins.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned j = 0; j < N; j++) begin
      scan_idx = {1'b0, ptr} + SW'(j);
      if (scan_idx >= SW'(N))
        scan_idx = scan_idx - SW'(N);
      if (!found && req[scan_idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_after_owner = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + ID_W'(1);
    owner_req       = |(req & gnt);
    others_wait     = |(req & ~gnt);
    timeout         = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD)) && others_wait;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            gnt       <= {{(N-1){1'b0}}, 1'b1} << winner;
            gnt_id    <= winner;
            gnt_valid <= 1'b1;
            hold_cnt  <= HC_W'(1);
          end else begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          // Voluntary release takes precedence over the timeout path.
          if (!owner_req || timeout) begin
            state     <= IDLE;
            ptr       <= ptr_after_owner;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            preempt   <= owner_req;
          end else if (hold_cnt < HC_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_id    <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
